// File: rtl/idiv_seq_if.sv
// Start/Ready/Done handshake and operand/result bus of the sequential divider.
// The controller drives the master side. The divider implements the slave side.
interface idiv_seq_if #(parameter int SIZE = 16);
    logic            start;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic            ready;
    logic            done;
    logic            div_by_zero;
    logic [SIZE-1:0] quotient;
    logic [SIZE-1:0] remainder;

    modport master (
        output start, a, b,
        input  ready, done, div_by_zero, quotient, remainder
    );

    modport slave (
        input  start, a, b,
        output ready, done, div_by_zero, quotient, remainder
    );
endinterface

// File: rtl/idiv_seq.sv
// Unsigned restoring divider, one quotient bit per cycle, or two per cycle when RADIX4_EN is defined.
// Latency: SIZE+1 cycles from the accepting edge to done (SIZE/2+1 with RADIX4_EN), 1 cycle when b==0.
// Backpressure: ready is low while BUSY and start is ignored there; a start in the DONE cycle is accepted back-to-back.
module idiv_seq #(
    parameter int SIZE = 16
) (
    input  logic      clock,
    input  logic      reset,
    idiv_seq_if.slave bus
);

`ifdef RADIX4_EN
    localparam int ITER = SIZE / 2;
`else
    localparam int ITER = SIZE;
`endif
    localparam int            CW   = $clog2(SIZE + 1);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_nxt;
    logic [SIZE-1:0] rem_q, dvd_q, div_q;
    logic [SIZE-1:0] rem_nxt, dvd_nxt;
    logic [CW-1:0]   cnt_q;
    logic [SIZE-1:0] quo_out, rem_out;
    logic            dbz_out;
    logic            accept, last;

    assign accept = bus.start && (state != BUSY);
    assign last   = (cnt_q == LAST);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        bus.ready = 1'b1;
        bus.done  = 1'b0;
        case (state)
            IDLE, DONE: begin
                bus.done = (state == DONE);
                if (bus.start) begin
                    state_nxt = (bus.b == '0) ? DONE : BUSY;
                end else begin
                    state_nxt = IDLE;
                end
            end
            BUSY: begin
                bus.ready = 1'b0;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef RADIX4_EN
    // Three times the divisor, formed once per operation so each step is compare-and-select only.
    logic [SIZE+1:0] b3_q;
    logic [SIZE+1:0] shifted;
    logic [SIZE-1:0] sub;
    logic [1:0]      qd;

    always_comb begin
        shifted = {rem_q, dvd_q[SIZE-1 -: 2]};
        qd      = 2'd0;
        sub     = '0;
        if (shifted >= b3_q) begin
            qd  = 2'd3;
            sub = b3_q[SIZE-1:0];
        end else if (shifted >= {1'b0, div_q, 1'b0}) begin
            qd  = 2'd2;
            sub = {div_q[SIZE-2:0], 1'b0};
        end else if (shifted >= {2'b00, div_q}) begin
            qd  = 2'd1;
            sub = div_q;
        end
        // The true difference is below the divisor, so the low SIZE bits hold it exactly.
        rem_nxt = shifted[SIZE-1:0] - sub;
        dvd_nxt = {dvd_q[SIZE-3:0], qd};
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            b3_q <= '0;
        end else if (accept) begin
            b3_q <= ({2'b00, bus.b} << 1) + {2'b00, bus.b};
        end
    end
`else
    // SIZE+1 bit partial remainder keeps the trial subtraction exact when the divisor MSB is set.
    logic [SIZE:0] shifted;
    logic          ge;

    always_comb begin
        shifted = {rem_q, dvd_q[SIZE-1]};
        ge      = (shifted >= {1'b0, div_q});
        rem_nxt = ge ? (shifted[SIZE-1:0] - div_q) : shifted[SIZE-1:0];
        dvd_nxt = {dvd_q[SIZE-2:0], ge};
    end
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            rem_q   <= '0;
            dvd_q   <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            quo_out <= '0;
            rem_out <= '0;
            dbz_out <= 1'b0;
        end else if (accept) begin
            rem_q <= '0;
            dvd_q <= bus.a;
            div_q <= bus.b;
            cnt_q <= '0;
            if (bus.b == '0) begin
                quo_out <= '1;
                rem_out <= bus.a;
                dbz_out <= 1'b1;
            end
        end else if (state == BUSY) begin
            rem_q <= rem_nxt;
            dvd_q <= dvd_nxt;
            cnt_q <= cnt_q + 1'b1;
            if (last) begin
                quo_out <= dvd_nxt;
                rem_out <= rem_nxt;
                dbz_out <= 1'b0;
            end
        end
    end

    assign bus.quotient    = quo_out;
    assign bus.remainder   = rem_out;
    assign bus.div_by_zero = dbz_out;

endmodule
